// File: rtl/i2c_bit_engine.sv
// i2c_bit_engine: byte-level I2C master engine.
// Consumes a quarter-bit tick from the baud generator and drives open-drain
// SCL/SDA enables (1 = pull low). Commands START/WRITE/READ/STOP arrive on a
// valid/ready handshake; each completes with a one-clk done pulse.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   iTick                 quarter-bit advance pulse
//   cmd_valid/cmd_ready   command handshake; cmd 00 START 01 WRITE 10 READ 11 STOP
//   wr_data, master_nack  WRITE byte / READ ack choice, captured at accept
//   rd_data, ack_rx       last READ byte / last WRITE slave ACK (1 = ACK)
//   done, err             completion pulse / WRITE or READ issued with bus free
//   bus_held              1 between a completed START and a completed STOP
//   scl_oe, sda_oe        open-drain pull-low enables
//   sda_in                synchronised SDA pin level
module i2c_bit_engine (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       iTick,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] wr_data,
   input  logic       master_nack,
   output logic [7:0] rd_data,
   output logic       ack_rx,
   output logic       done,
   output logic       err,
   output logic       bus_held,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in
);

   localparam logic [1:0] CmdStart = 2'b00;
   localparam logic [1:0] CmdWrite = 2'b01;
   localparam logic [1:0] CmdRead  = 2'b10;
   localparam logic [1:0] CmdStop  = 2'b11;

   typedef enum logic [2:0] {StIdle, StHeld, StStart, StData, StAck, StStop} state_e;

   state_e     state_q, state_d;
   logic [1:0] qtr_q, qtr_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [1:0] cmd_q, cmd_d;
   logic       nack_q, nack_d;
   logic       scl_q, scl_d;
   logic       sda_q, sda_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       ack_q, ack_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       held_q, held_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         qtr_q     <= 2'd0;
         bit_q     <= 3'd0;
         shift_q   <= 8'h00;
         cmd_q     <= CmdStart;
         nack_q    <= 1'b0;
         scl_q     <= 1'b0;
         sda_q     <= 1'b0;
         rd_data_q <= 8'h00;
         ack_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         cmd_q     <= cmd_d;
         nack_q    <= nack_d;
         scl_q     <= scl_d;
         sda_q     <= sda_d;
         rd_data_q <= rd_data_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         err_q     <= err_d;
         held_q    <= held_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      qtr_d     = qtr_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      cmd_d     = cmd_q;
      nack_d    = nack_q;
      scl_d     = scl_q;
      sda_d     = sda_q;
      rd_data_d = rd_data_q;
      ack_d     = ack_q;
      held_d    = held_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         StIdle, StHeld: begin
            if (cmd_valid) begin
               cmd_d   = cmd;
               shift_d = wr_data;
               nack_d  = master_nack;
               qtr_d   = 2'd0;
               bit_d   = 3'd0;
               if (cmd == CmdStart) begin
                  state_d = StStart;
               end else if (state_q == StHeld && cmd != CmdStop) begin
                  state_d = StData;
               end else begin
                  // STOP, or WRITE/READ with the bus free: StStop completes it
                  // without touching the bus when held_q is clear.
                  state_d = StStop;
               end
            end
         end

         StStart: begin
            if (iTick) begin
               qtr_d = qtr_q + 2'd1;
               unique case (qtr_q)
                  2'd0: sda_d = 1'b0;
                  2'd1: scl_d = 1'b0;
                  2'd2: sda_d = 1'b1;   // SDA falls with SCL released
                  2'd3: begin
                     scl_d   = 1'b1;
                     held_d  = 1'b1;
                     done_d  = 1'b1;
                     state_d = StHeld;
                  end
               endcase
            end
         end

         StData: begin
            if (iTick) begin
               qtr_d = qtr_q + 2'd1;
               unique case (qtr_q)
                  2'd0: begin
                     scl_d = 1'b1;
                     sda_d = (cmd_q == CmdWrite) ? ~shift_q[7] : 1'b0;
                  end
                  2'd1: scl_d = 1'b0;
                  2'd2: begin
                     if (cmd_q == CmdRead) shift_d = {shift_q[6:0], sda_in};
                  end
                  2'd3: begin
                     scl_d = 1'b1;
                     if (cmd_q == CmdWrite) shift_d = {shift_q[6:0], 1'b0};
                     bit_d = bit_q + 3'd1;
                     if (bit_q == 3'd7) state_d = StAck;
                  end
               endcase
            end
         end

         StAck: begin
            if (iTick) begin
               qtr_d = qtr_q + 2'd1;
               unique case (qtr_q)
                  2'd0: begin
                     scl_d = 1'b1;
                     sda_d = (cmd_q == CmdWrite) ? 1'b0 : ~nack_q;
                  end
                  2'd1: scl_d = 1'b0;
                  2'd2: begin
                     if (cmd_q == CmdWrite) ack_d = ~sda_in;
                  end
                  2'd3: begin
                     scl_d   = 1'b1;
                     done_d  = 1'b1;
                     state_d = StHeld;
                     if (cmd_q == CmdRead) rd_data_d = shift_q;
                  end
               endcase
            end
         end

         StStop: begin
            if (iTick) begin
               if (!held_q) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                  err_d   = (cmd_q != CmdStop);
               end else begin
                  qtr_d = qtr_q + 2'd1;
                  unique case (qtr_q)
                     2'd0: begin
                        scl_d = 1'b1;
                        sda_d = 1'b1;
                     end
                     2'd1: scl_d = 1'b0;
                     2'd2: sda_d = 1'b0;   // SDA rises with SCL released
                     2'd3: begin
                        held_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                     end
                  endcase
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   assign cmd_ready = (state_q == StIdle) || (state_q == StHeld);
   assign rd_data   = rd_data_q;
   assign ack_rx    = ack_q;
   assign done      = done_q;
   assign err       = err_q;
   assign bus_held  = held_q;
   assign scl_oe    = scl_q;
   assign sda_oe    = sda_q;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Directed bench for i2c_bit_engine: tick every 4 clks (or every clk for the
// back-to-back case), open-drain SDA resolved with a simple slave pull-down.
module tb_i2c_bit_engine;

   localparam logic [1:0] CmdStart = 2'b00;
   localparam logic [1:0] CmdWrite = 2'b01;
   localparam logic [1:0] CmdRead  = 2'b10;
   localparam logic [1:0] CmdStop  = 2'b11;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       iTick;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd;
   logic [7:0] wr_data;
   logic       master_nack;
   logic [7:0] rd_data;
   logic       ack_rx;
   logic       done;
   logic       err;
   logic       bus_held;
   logic       scl_oe;
   logic       sda_oe;
   logic       sda_in;
   logic       slave_low;

   int n_checks = 0;
   int n_errors = 0;
   bit tick_cont = 1'b0;
   int unsigned tick_div = 0;

   assign sda_in = ~(sda_oe | slave_low);

   i2c_bit_engine dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .iTick       (iTick),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd         (cmd),
      .wr_data     (wr_data),
      .master_nack (master_nack),
      .rd_data     (rd_data),
      .ack_rx      (ack_rx),
      .done        (done),
      .err         (err),
      .bus_held    (bus_held),
      .scl_oe      (scl_oe),
      .sda_oe      (sda_oe),
      .sda_in      (sda_in)
   );

   always #5 clk = ~clk;

   initial begin
      iTick = 1'b0;
      forever begin
         @(negedge clk);
         tick_div++;
         iTick = tick_cont || (tick_div % 4 == 0);
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Wait for the next clk edge that carries a tick, then step off the edge.
   task automatic tick_edge();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!iTick && n < 20);
      if (!iTick) check_eq("tick_wait", {31'd0, iTick}, 1);
      #1;
   endtask

   task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic nk);
      int n = 0;
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd         = c;
      wr_data     = d;
      master_nack = nk;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check_eq("cmd_ready_wait", {31'd0, cmd_ready}, 1);
      @(posedge clk);
      #1;
      // Scramble inputs after accept; the engine must ignore them.
      cmd_valid   = 1'b0;
      cmd         = ~c;
      wr_data     = ~d;
      master_nack = ~nk;
   endtask

   // Four ticks, recording {scl_oe,sda_oe} after each, oldest in the MSBs.
   task automatic run4(output logic [7:0] tr);
      tr = 8'h00;
      repeat (4) begin
         tick_edge();
         tr = {tr[5:0], scl_oe, sda_oe};
      end
   endtask

   initial begin
      logic [7:0]  tr;
      logic [7:0]  sda_bits;
      logic [7:0]  rd_shift;
      logic [31:0] rnd;
      logic [9:0]  dtr;
      int          bad;
      int          scl_bad;
      int          early;

      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      cmd         = CmdStart;
      wr_data     = 8'h00;
      master_nack = 1'b0;
      slave_low   = 1'b0;

      // Reset with random inputs.
      repeat (8) begin
         @(negedge clk);
         rnd         = $urandom;
         cmd_valid   = rnd[0];
         cmd         = rnd[2:1];
         wr_data     = rnd[10:3];
         master_nack = rnd[11];
         slave_low   = rnd[12];
         #1;
         check_eq("reset_outputs",
                  {17'd0, scl_oe, sda_oe, cmd_ready, done, err, bus_held, ack_rx, rd_data},
                  {17'd0, 2'b00, 1'b1, 3'b000, 1'b0, 8'h00});
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      slave_low = 1'b0;
      reset_n   = 1'b1;

      // Quiet bus for 100 ticks.
      bad = 0;
      repeat (100) begin
         tick_edge();
         if ({scl_oe, sda_oe, cmd_ready, done, err, bus_held} !== 6'b001000) bad++;
      end
      check_eq("idle_quiet", bad, 0);

      // WRITE with the bus free: done+err on first tick, no bus activity.
      issue(CmdWrite, 8'h55, 1'b0);
      tick_edge();
      check_eq("idle_write_done_err", {27'd0, done, err, scl_oe, sda_oe, bus_held}, 5'b11000);
      @(posedge clk);
      #1;
      check_eq("idle_write_pulse_end", {29'd0, done, err, cmd_ready}, 3'b001);

      // STOP with the bus free: done only.
      issue(CmdStop, 8'h00, 1'b0);
      tick_edge();
      check_eq("idle_stop_noop", {27'd0, done, err, scl_oe, sda_oe, bus_held}, 5'b10000);

      // START from IDLE.
      issue(CmdStart, 8'h00, 1'b0);
      run4(tr);
      check_eq("start_trace", tr, 8'h07);
      check_eq("start_done", {29'd0, done, err, bus_held}, 3'b101);

      // WRITE 0xA5, slave ACKs.
      issue(CmdWrite, 8'hA5, 1'b0);
      sda_bits = 8'h00;
      scl_bad  = 0;
      early    = 0;
      for (int k = 1; k <= 36; k++) begin
         tick_edge();
         if (k <= 32 && k % 4 == 1) sda_bits = {sda_bits[6:0], sda_oe};
         if (scl_oe !== ((k % 4 == 1) || (k % 4 == 0))) scl_bad++;
         if (k < 36 && done) early++;
         if (k == 36) check_eq("write_done", {28'd0, done, err, ack_rx, bus_held}, 4'b1011);
         if (k == 33) slave_low = 1'b1;
         if (k == 36) slave_low = 1'b0;
      end
      check_eq("write_sda_bits", sda_bits, 8'h5A);
      check_eq("write_scl_pattern", scl_bad, 0);
      check_eq("write_no_early_done", early, 0);

      // READ, slave sends 0x3C, master NACKs.
      issue(CmdRead, 8'h00, 1'b1);
      rd_shift = 8'h3C;
      bad      = 0;
      for (int k = 1; k <= 36; k++) begin
         tick_edge();
         if (sda_oe) bad++;
         if (k == 36) begin
            check_eq("read_data", rd_data, 8'h3C);
            check_eq("read_done", {28'd0, done, err, ack_rx, bus_held}, 4'b1011);
         end
         if (k <= 32 && k % 4 == 1) begin
            slave_low = ~rd_shift[7];
            rd_shift  = {rd_shift[6:0], 1'b0};
         end
         if (k == 33) slave_low = 1'b0;
      end
      check_eq("read_master_sda_released", bad, 0);

      // Repeated START from HELD.
      issue(CmdStart, 8'h00, 1'b0);
      run4(tr);
      check_eq("rstart_trace", tr, 8'h87);
      check_eq("rstart_done", {29'd0, done, err, bus_held}, 3'b101);

      // STOP.
      issue(CmdStop, 8'h00, 1'b0);
      run4(tr);
      check_eq("stop_trace", tr, 8'hD0);
      check_eq("stop_done", {28'd0, done, err, bus_held, cmd_ready}, 4'b1001);

      // Reset during bit 4 of a WRITE.
      issue(CmdStart, 8'h00, 1'b0);
      run4(tr);
      issue(CmdWrite, 8'h00, 1'b0);
      repeat (17) tick_edge();
      check_eq("midwrite_lines", {30'd0, scl_oe, sda_oe}, 2'b11);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("async_reset", {27'd0, scl_oe, sda_oe, cmd_ready, bus_held, done}, 5'b00100);
      @(negedge clk);
      reset_n = 1'b1;
      issue(CmdStart, 8'h00, 1'b0);
      run4(tr);
      check_eq("post_reset_start", tr, 8'h07);
      check_eq("post_reset_held", {30'd0, done, bus_held}, 2'b11);

      // Back-to-back START then STOP with iTick high continuously.
      tick_cont = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd       = CmdStart;
      @(posedge clk);
      #1;
      cmd = CmdStop;
      dtr = 10'd0;
      for (int e = 1; e <= 9; e++) begin
         @(posedge clk);
         #1;
         dtr[e] = done;
         if (e == 5) cmd_valid = 1'b0;
      end
      check_eq("b2b_done_timing", dtr, 10'h210);
      check_eq("b2b_final", {29'd0, bus_held, cmd_ready, sda_oe}, 3'b010);
      tick_cont = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_bit_engine.md
Name: i2c_bit_engine

Overview:
Byte-level I2C master engine that consumes the single-cycle tick from the baud generator and produces open-drain SCL/SDA enables. Each tick advances one quarter of an I2C bit period, so SCL frequency = tick rate / 4. It accepts START, WRITE, READ and STOP commands over a valid/ready handshake and reports the received data and ACK per command. It sits between the baud generator and the transaction-level I2C controller.

Parameters:
None. Bus timing is set entirely by the tick rate from the upstream baud generator.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
iTick  in  1  quarter-bit pulse from baud generator, one clk wide
cmd_valid  in  1  command request
cmd_ready  out  1  engine can accept a command
cmd  in  2  00 START (also repeated start), 01 WRITE, 10 READ, 11 STOP
wr_data  in  8  byte for WRITE, captured at accept
master_nack  in  1  for READ: 1 = send NACK, 0 = send ACK; captured at accept
rd_data  out  8  byte received by last READ
ack_rx  out  1  slave ACK from last WRITE (1 = ACK, i.e. SDA sampled 0)
done  out  1  one-clk pulse when a command completes
err  out  1  one-clk pulse with done when WRITE/READ is issued while bus free
bus_held  out  1  1 between a completed START and a completed STOP
scl_oe  out  1  1 = pull SCL low
sda_oe  out  1  1 = pull SDA low
sda_in  in  1  synchronised SDA pin level

Behaviour:
- One clock domain, clk. reset_n is asynchronous and active-low. While reset_n = 0: state IDLE, scl_oe=0, sda_oe=0, cmd_ready=1, rd_data=0, ack_rx=0, done=0, err=0, bus_held=0, quarter counter=0, bit counter=0.
- Asserting reset_n low mid-command aborts the command immediately: both lines are released, with no STOP generated.
- States: IDLE, HELD, START, DATA, ACK, STOP.
- cmd_ready=1 only in IDLE and HELD. A command is accepted on a clk edge with cmd_valid&cmd_ready. cmd_ready drops on the next cycle.
- Execution begins on the first iTick after accept. Every phase change occurs only on clk edges where iTick=1. Quarter counter q runs 0..3.
- START (from IDLE or HELD):
  - q0: sda_oe=0, scl_oe unchanged.
  - q1: scl_oe=0.
  - q2: sda_oe=1.
  - q3: scl_oe=1. Then HELD, bus_held=1, done.
  - SDA never changes while SCL is released except in q2 (the START condition).
- WRITE (HELD only): 8 bits MSB first, then ACK. Per bit:
  - q0: scl_oe=1, sda_oe = ~bit.
  - q1: scl_oe=0.
  - q2: hold.
  - q3: scl_oe=1.
  - ACK slot: sda_oe=0 and sda_in is sampled at q2, giving ack_rx = ~sda_in. The slot ends with scl_oe=1, then HELD and done. Total 36 ticks.
- READ (HELD only): 8 bits with sda_oe=0. Sample sda_in at q2 of each bit, shifting MSB first. ACK slot drives sda_oe = ~master_nack. rd_data is updated at done. Total 36 ticks.
- STOP (HELD only; in IDLE it is a no-op with done and err=0):
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl_oe=0.
  - q2: sda_oe=0.
  - q3: enter IDLE, bus_held=0, done.
- WRITE or READ issued in IDLE: no bus activity. done and err pulse on the first tick after accept; state stays IDLE.
- done and err are single-clk pulses coincident with the final-tick edge. cmd_ready returns to 1 on that same edge, so a back-to-back command may be accepted the very next cycle.
- cmd_valid while not ready is ignored; the initiator must hold it. wr_data and cmd changes after accept have no effect.
- iTick held high continuously is legal: the engine advances one quarter per clk.
- Bit counter is 3 bits and wraps 7→0 on entering ACK. No arithmetic beyond the counters.

Test Plan:
- Reset: hold reset_n=0 with random inputs → scl_oe=sda_oe=0, cmd_ready=1, done=0. Release, send no commands for 100 ticks → outputs unchanged.
- START then WRITE 0xA5 with slave model pulling SDA low in the ACK slot → sda_oe bit pattern 0,1,0,1,1,0,1,0 (sda_oe=~bit, MSB first) across 32 ticks. ack_rx=1, done after 36 ticks, bus_held=1.
- READ with slave driving 0x3C and master_nack=1 → rd_data=0x3C, sda_oe=0 during the ACK slot. Then STOP → SDA rises while SCL is released, bus_held=0.
- Repeated START from HELD → SDA released with SCL low, then SCL released, then SDA falls. No STOP condition appears on the bus.
- WRITE issued in IDLE → done=1 and err=1 on the first tick, scl_oe/sda_oe stay 0 throughout.
- reset_n pulsed low at bit 4 of a WRITE → lines released asynchronously, state IDLE, a following START executes normally. Back-to-back commands accepted on the cycle after done → no idle tick inserted.
